tft_ctrl: RTL and testbench

//  Timing generator for the 480x272 RGB565 TFT panel, clocked at 9 MHz.

---
 rtl/tft_ctrl.sv | 90 +++++++++
 tb/tb_tft_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tft_ctrl.sv
// Scan timing generator for a 480x272 RGB565 TFT panel at 9 MHz: counters,
// sync/DE decode, one-cycle-early pixel request and panel pin drive.
module tft_ctrl #(
    parameter logic [9:0] H_SYNC  = 10'd41,
    parameter logic [9:0] H_BACK  = 10'd2,
    parameter logic [9:0] H_VALID = 10'd480,
    parameter logic [9:0] H_FRONT = 10'd2,
    parameter logic [9:0] H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT,
    parameter logic [9:0] V_SYNC  = 10'd10,
    parameter logic [9:0] V_BACK  = 10'd2,
    parameter logic [9:0] V_VALID = 10'd272,
    parameter logic [9:0] V_FRONT = 10'd2,
    parameter logic [9:0] V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT
) (
    input  logic        clk_9m,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [15:0] rgb_tft,
    output logic        hsync,
    output logic        vsync,
    output logic        tft_clk,
    output logic        tft_de,
    output logic        tft_bl
);

    localparam logic [9:0] H_ACT_START = H_SYNC + H_BACK;
    localparam logic [9:0] H_ACT_END   = H_ACT_START + H_VALID;
    localparam logic [9:0] H_REQ_START = H_ACT_START - 10'd1;
    localparam logic [9:0] H_REQ_END   = H_ACT_END - 10'd1;
    localparam logic [9:0] V_ACT_START = V_SYNC + V_BACK;
    localparam logic [9:0] V_ACT_END   = V_ACT_START + V_VALID;

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       h_end;
    logic       v_end;
    logic       v_active;
    logic       rgb_valid;
    logic       pix_req;

    assign h_end = (cnt_h == H_TOTAL - 10'd1);
    assign v_end = (cnt_v == V_TOTAL - 10'd1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the asynchronous clear returns the scan to the origin
    // immediately, even mid-frame.
    always_ff @(posedge clk_9m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h <= '0;
        end else if (h_end) begin
            cnt_h <= '0;
        end else begin
            cnt_h <= cnt_h + 10'd1;
        end
    end

    always_ff @(posedge clk_9m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_v <= '0;
        end else if (h_end) begin
            if (v_end) begin
                cnt_v <= '0;
            end else begin
                cnt_v <= cnt_v + 10'd1;
            end
        end
    end

    assign hsync = (cnt_h <= H_SYNC - 10'd1);
    assign vsync = (cnt_v <= V_SYNC - 10'd1);

    assign v_active  = (cnt_v >= V_ACT_START) && (cnt_v < V_ACT_END);
    assign rgb_valid = (cnt_h >= H_ACT_START) && (cnt_h < H_ACT_END) && v_active;

    // Requests lead the active window by one clock to cover the registered
    // stage in the downstream pixel generator.
    assign pix_req = (cnt_h >= H_REQ_START) && (cnt_h < H_REQ_END) && v_active;

    assign pix_x = pix_req ? (cnt_h - H_REQ_START) : 10'h3ff;
    assign pix_y = pix_req ? (cnt_v - V_ACT_START) : 10'h3ff;

    // Gating by rgb_valid keeps an unknown pix_data outside the window off the pins.
    assign rgb_tft = rgb_valid ? pix_data : 16'h0000;
    assign tft_de  = rgb_valid;
    assign tft_clk = clk_9m;
    assign tft_bl  = sys_rst_n;

endmodule

// File: tb/tb_tft_ctrl.sv
// Directed bench for tft_ctrl: a full-size instance plus a short-frame instance
// so that frame wrap-around is reached within a short run.
module tb_tft_ctrl;

    localparam int S_VV = 16;
    localparam int S_VT = 10 + 2 + S_VV + 2;

    logic        clk_9m = 1'b0;
    logic        sys_rst_n = 1'b0;

    logic [15:0] pix_data, s_pix_data;
    logic [9:0]  pix_x, pix_y, s_pix_x, s_pix_y;
    logic [9:0]  pix_x_d1, pix_y_d1, s_pix_x_d1, s_pix_y_d1;
    logic [15:0] rgb_tft, s_rgb_tft;
    logic        hsync, vsync, tft_clk, tft_de, tft_bl;
    logic        s_hsync, s_vsync, s_tft_clk, s_tft_de, s_tft_bl;

    bit ff_mode = 1'b0;
    int idx;
    int n_cmp = 0;
    int n_bad = 0;
    int bad_m = 0, bad_s = 0;
    int hs_l0 = 0, s_vs_f0 = 0, s_de_f0 = 0, s_lines_f0 = 0, s_de_2f = 0;
    int m_de_l12 = 0, m_de_early = 0;

    tft_ctrl dut (
        .clk_9m   (clk_9m),
        .sys_rst_n(sys_rst_n),
        .pix_data (pix_data),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .rgb_tft  (rgb_tft),
        .hsync    (hsync),
        .vsync    (vsync),
        .tft_clk  (tft_clk),
        .tft_de   (tft_de),
        .tft_bl   (tft_bl)
    );

    tft_ctrl #(.V_VALID(10'(S_VV))) dut_s (
        .clk_9m   (clk_9m),
        .sys_rst_n(sys_rst_n),
        .pix_data (s_pix_data),
        .pix_x    (s_pix_x),
        .pix_y    (s_pix_y),
        .rgb_tft  (s_rgb_tft),
        .hsync    (s_hsync),
        .vsync    (s_vsync),
        .tft_clk  (s_tft_clk),
        .tft_de   (s_tft_de),
        .tft_bl   (s_tft_bl)
    );

    always #5 clk_9m = ~clk_9m;

    // Downstream pixel generator: registered coordinates, unknown data outside the window.
    always @(posedge clk_9m) begin
        pix_x_d1   <= pix_x;
        pix_y_d1   <= pix_y;
        s_pix_x_d1 <= s_pix_x;
        s_pix_y_d1 <= s_pix_y;
    end

    always_comb begin
        pix_data   = 16'hxxxx;
        s_pix_data = 16'hxxxx;
        if (ff_mode) begin
            pix_data   = 16'hFFFF;
            s_pix_data = 16'hFFFF;
        end else begin
            if (pix_x_d1 != 10'h3ff) pix_data = {~pix_y_d1[5:0], pix_x_d1};
            if (s_pix_x_d1 != 10'h3ff) s_pix_data = {~s_pix_y_d1[5:0], s_pix_x_d1};
        end
    end

    // Expected {hsync, vsync, de, pix_x, pix_y, rgb} after i clocks since reset release.
    function automatic logic [38:0] model(input int i, input int v_total, input int v_valid,
                                          input bit ff);
        int eh, ev;
        logic hs, vs, de, rq;
        logic [9:0] px, py, xx, yy;
        logic [15:0] rgb;
        eh  = i % 525;
        ev  = (i / 525) % v_total;
        hs  = (eh < 41);
        vs  = (ev < 10);
        rq  = (eh >= 42) && (eh < 522) && (ev >= 12) && (ev < 12 + v_valid);
        de  = (eh >= 43) && (eh < 523) && (ev >= 12) && (ev < 12 + v_valid);
        px  = rq ? 10'(eh - 42) : 10'h3ff;
        py  = rq ? 10'(ev - 12) : 10'h3ff;
        xx  = 10'(eh - 43);
        yy  = 10'(ev - 12);
        rgb = !de ? 16'h0000 : (ff ? 16'hFFFF : {~yy[5:0], xx});
        return {hs, vs, de, px, py, rgb};
    endfunction

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        if ({hsync, vsync, tft_de, pix_x, pix_y, rgb_tft} !== model(idx, 286, 272, ff_mode))
            bad_m++;
        if ({s_hsync, s_vsync, s_tft_de, s_pix_x, s_pix_y, s_rgb_tft}
            !== model(idx, S_VT, S_VV, ff_mode))
            bad_s++;
        if (idx < 525 && hsync) hs_l0++;
        if (idx < 525 * S_VT) begin
            if (s_vsync) s_vs_f0++;
            if (s_tft_de) s_de_f0++;
            if (idx % 525 == 43 && s_tft_de) s_lines_f0++;
        end
        if (idx < 2 * 525 * S_VT && s_tft_de) s_de_2f++;
        if (idx / 525 == 12 && tft_de) m_de_l12++;
        if (idx < 6343 && tft_de) m_de_early++;
    endtask

    task automatic run_to(input int target);
        while (idx < target) begin
            @(posedge clk_9m);
            @(negedge clk_9m);
            idx++;
            sample();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idx = 0;
        repeat (2) @(negedge clk_9m);
        check("in_reset", {hsync, vsync, tft_de, tft_bl, pix_x, pix_y, rgb_tft},
              {1'b1, 1'b1, 1'b0, 1'b0, 10'h3ff, 10'h3ff, 16'h0000});
        check("clk_low", {38'd0, tft_clk, s_tft_clk}, 40'd0);

        // Phase A: ramp pixels, full-size and short-frame panels together.
        sys_rst_n = 1'b1;
        #1;
        sample();
        check("after_release", {hsync, vsync, tft_de, tft_bl, pix_x, pix_y, rgb_tft},
              {1'b1, 1'b1, 1'b0, 1'b1, 10'h3ff, 10'h3ff, 16'h0000});
        run_to(524);
        check("hsync_width", 40'(hs_l0), 40'd41);
        run_to(6342);
        check("first_req", {tft_de, pix_x, pix_y}, {1'b0, 10'd0, 10'd0});
        run_to(6343);
        check("first_de", {tft_de, rgb_tft}, {1'b1, 16'hFC00});
        check("first_de_s", {s_tft_de, s_rgb_tft}, {1'b1, 16'hFC00});
        run_to(6821);
        check("last_req", {tft_de, pix_x, rgb_tft}, {1'b1, 10'd479, 16'hFDDE});
        run_to(6822);
        check("last_pix", {tft_de, pix_x, pix_y, rgb_tft}, {1'b1, 10'h3ff, 10'h3ff, 16'hFDDF});
        run_to(6823);
        check("de_off", {tft_de, rgb_tft}, {1'b0, 16'h0000});
        run_to(27 * 525 + 42);
        check("s_last_line", {s_pix_x, s_pix_y}, {10'd0, 10'd15});
        run_to(28 * 525 + 42);
        check("s_after_last", {s_pix_x, s_pix_y}, {10'h3ff, 10'h3ff});
        run_to(525 * S_VT - 1);
        check("s_frame_end", {s_hsync, s_vsync, s_tft_de}, {1'b0, 1'b0, 1'b0});
        check("s_vsync_width", 40'(s_vs_f0), 40'd5250);
        check("s_de_lines", 40'(s_lines_f0), 40'(S_VV));
        check("s_de_clocks_f0", 40'(s_de_f0), 40'(S_VV * 480));
        run_to(525 * S_VT);
        check("s_wrap", {s_hsync, s_vsync, s_pix_y}, {1'b1, 1'b1, 10'h3ff});
        run_to(525 * S_VT + 6342);
        check("s_frame2_req", {s_pix_x, s_pix_y}, {10'd0, 10'd0});
        run_to(2 * 525 * S_VT);
        check("s_de_clocks_2f", 40'(s_de_2f), 40'(2 * S_VV * 480));
        run_to(100 * 525 + 300);
        check("pre_reset", {hsync, vsync, tft_de, pix_x, pix_y, rgb_tft},
              {1'b0, 1'b0, 1'b1, 10'd258, 10'd88, 16'h9D01});
        check("scan_main_a", 40'(bad_m), 40'd0);
        check("scan_short_a", 40'(bad_s), 40'd0);

        // Phase B: asynchronous reset mid-frame, held for three clocks.
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("async_reset", {hsync, vsync, tft_de, tft_bl, pix_x, pix_y, rgb_tft},
              {1'b1, 1'b1, 1'b0, 1'b0, 10'h3ff, 10'h3ff, 16'h0000});
        repeat (3) begin
            @(posedge clk_9m);
            #1;
        end
        check("clk_high", {38'd0, tft_clk, s_tft_clk}, 40'd3);
        @(negedge clk_9m);
        check("held_reset", {hsync, vsync, tft_de, tft_bl, s_tft_bl, pix_x, pix_y, rgb_tft},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3ff, 10'h3ff, 16'h0000});

        // Phase C: restart from origin with constant all-ones pixel data.
        ff_mode    = 1'b1;
        sys_rst_n  = 1'b1;
        idx        = 0;
        m_de_l12   = 0;
        m_de_early = 0;
        #1;
        sample();
        run_to(6342);
        check("restart_req", {tft_de, pix_x, pix_y, rgb_tft}, {1'b0, 10'd0, 10'd0, 16'h0000});
        check("no_early_de", 40'(m_de_early), 40'd0);
        run_to(6343);
        check("restart_de", {tft_de, rgb_tft}, {1'b1, 16'hFFFF});
        run_to(6823);
        check("porch_blank", {tft_de, rgb_tft, pix_x}, {1'b0, 16'h0000, 10'h3ff});
        run_to(13 * 525);
        check("de_per_line", 40'(m_de_l12), 40'd480);
        check("scan_main_c", 40'(bad_m), 40'd0);
        check("scan_short_c", 40'(bad_s), 40'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
